// File: rtl/fetch_stage_pkg.sv
// Shared ISA defines: opcode constants, NOP encoding, reset PC and
// small decode helpers used by the pipeline stages.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;
  localparam logic [XLEN-1:0] RESET_PC  = 16'h0000;

  function automatic logic is_hlt(input logic [XLEN-1:0] instr);
    return instr[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-addressed PC, request/ack instruction
// memory handshake, one-entry stall buffer and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_redirect,
  input  logic [15:0]     i_target,
  output logic            o_imReq,
  output logic [15:0]     o_imAddr,
  input  logic            i_imAck,
  input  logic [15:0]     i_imData,
  output logic [15:0]     o_instr,
  output logic [15:0]     o_pc,
  output logic            o_valid,
  output logic            o_hlt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_ifpc;
  logic        r_valid;
  logic [15:0] r_buf;

  logic [15:0] w_pc_nx;
  logic [15:0] w_instr_nx;
  logic [15:0] w_ifpc_nx;
  logic        w_valid_nx;
  logic [15:0] w_buf_nx;
  logic [15:0] w_pc_inc;
  logic        w_take;

  assign w_pc_inc = r_pc + 16'd1;
  assign w_take   = (r_state == S_REQ) && i_imAck;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_instr_nx = r_instr;
    w_ifpc_nx  = r_ifpc;
    w_valid_nx = r_valid;
    w_buf_nx   = r_buf;

    if (i_redirect) begin
      w_pc_nx    = i_target;
      w_instr_nx = NOP_INSTR;
      w_valid_nx = 1'b0;
      w_buf_nx   = NOP_INSTR;
      w_state_nx = S_REQ;
    end else if (i_flush) begin
      w_instr_nx = NOP_INSTR;
      w_valid_nx = 1'b0;
      // PC already advanced past the buffered word; step back so it is refetched.
      if (r_state == S_HOLD) begin
        w_pc_nx    = r_pc - 16'd1;
        w_buf_nx   = NOP_INSTR;
        w_state_nx = S_REQ;
      end
    end else if (i_stall) begin
      if (w_take) begin
        w_buf_nx   = i_imData;
        w_pc_nx    = w_pc_inc;
        w_state_nx = S_HOLD;
      end
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (i_imAck) begin
            w_instr_nx = i_imData;
            w_ifpc_nx  = w_pc_inc;
            w_valid_nx = 1'b1;
            w_pc_nx    = w_pc_inc;
            w_state_nx = is_hlt(i_imData) ? S_HALT : S_REQ;
          end else begin
            w_instr_nx = NOP_INSTR;
            w_valid_nx = 1'b0;
          end
        end
        S_HOLD: begin
          w_instr_nx = r_buf;
          w_ifpc_nx  = r_pc;
          w_valid_nx = 1'b1;
          w_buf_nx   = NOP_INSTR;
          w_state_nx = is_hlt(r_buf) ? S_HALT : S_REQ;
        end
        S_HALT: begin
          w_state_nx = S_HALT;
        end
        default: begin
          w_state_nx = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_ifpc  <= '0;
      r_valid <= 1'b0;
      r_buf   <= NOP_INSTR;
    end else begin
      r_pc    <= w_pc_nx;
      r_instr <= w_instr_nx;
      r_ifpc  <= w_ifpc_nx;
      r_valid <= w_valid_nx;
      r_buf   <= w_buf_nx;
    end
  end

  assign o_imReq  = (r_state == S_REQ) && !i_rst;
  assign o_imAddr = r_pc;
  assign o_instr  = r_instr;
  assign o_pc     = r_ifpc;
  assign o_valid  = r_valid;
  assign o_hlt    = (r_state == S_HALT);

endmodule
